// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - burst reader for a sync-read block RAM with a 2-entry stream buffer
// Optional feature macro: BRAM_STREAM_READER_STRIDE_EN (per-burst address stride port).
module bram_stream_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
`ifdef BRAM_STREAM_READER_STRIDE_EN
  input  logic [ADDRW-1:0] stride,
`endif
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_read,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0] ONE_W   = (ADDRW+1)'(1);

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   left_q, left_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic [WIDTH-1:0] fifo_data_q [2];
  logic [WIDTH-1:0] fifo_data_d [2];
  logic [1:0]       fifo_last_q, fifo_last_d;
  logic             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             done_q, done_d;

  logic             push, pop, issue, accept;
  logic [2:0]       occ;
  logic [ADDRW-1:0] step;
  logic [ADDRW:0]   addr_sum, addr_wrap;

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = fifo_data_q[rd_ptr_q];
  assign m_last    = m_valid & fifo_last_q[rd_ptr_q];
  assign busy      = (state_q != S_IDLE) | done_q;
  assign done      = done_q;
  assign addr_read = addr_q;

  assign push   = inflight_q;
  assign pop    = m_valid & m_ready;
  assign accept = (state_q == S_IDLE) & ~done_q & start & (len != '0);

  // A read issued now lands next cycle, so it needs a free slot once this cycle's push/pop settle.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_RUN) && (occ < 3'd2);

  assign addr_sum  = {1'b0, addr_q} + {1'b0, step};
  assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

`ifdef BRAM_STREAM_READER_STRIDE_EN
  logic [ADDRW-1:0] stride_q, stride_d;
  assign stride_d = accept ? stride : stride_q;
  assign step     = stride_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stride_q <= '0;
    else        stride_q <= stride_d;
  end
`else
  assign step = ADDRW'(1);
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    left_d          = left_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (left_q == ONE_W);
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = data_in;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          left_d  = len;
        end else if (start && !done_q) begin
          done_d = 1'b1;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_wrap[ADDRW-1:0];
          left_d = left_q - ONE_W;
          if (left_q == ONE_W) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pop && m_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      left_q          <= left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - randomized self-checking bench for bram_stream_reader
`timescale 1ns/1ps
module tb_bram_stream_reader;
  localparam int DA = 256;
  localparam int DB = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a, busy_a, done_a, valid_a, ready_a, last_a;
  logic [7:0] base_a, stride_a, raddr_a, din_a, data_a;
  logic [8:0] len_a;
  logic       start_b, busy_b, done_b, valid_b, ready_b, last_b;
  logic [7:0] base_b, stride_b, raddr_b, din_b, data_b;
  logic [8:0] len_b;

  logic [7:0] mem_a [DA];
  logic [7:0] mem_b [DB];
  always @(posedge clk) din_a <= mem_a[raddr_a];
  always @(posedge clk) din_b <= mem_b[raddr_b];

  int passed = 0;
  int total  = 0;

  bram_stream_reader #(.WIDTH(8), .DEPTH(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a), .len(len_a),
`ifdef BRAM_STREAM_READER_STRIDE_EN
    .stride(stride_a),
`endif
    .busy(busy_a), .done(done_a), .addr_read(raddr_a), .data_in(din_a),
    .m_data(data_a), .m_valid(valid_a), .m_ready(ready_a), .m_last(last_a));

  bram_stream_reader #(.WIDTH(8), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .len(len_b),
`ifdef BRAM_STREAM_READER_STRIDE_EN
    .stride(stride_b),
`endif
    .busy(busy_b), .done(done_b), .addr_read(raddr_b), .data_in(din_b),
    .m_data(data_b), .m_valid(valid_b), .m_ready(ready_b), .m_last(last_b));

  // mode 0: always ready, 1: random ready, 2: repeating 1,0,0,1,0,1 pattern
  task automatic burst_a(input logic [7:0] b, input int n, input int mode, input bit poke);
    logic [7:0] exp_q[$];
    logic [7:0] prev_data, lead;
    logic       prev_last;
    int         cyc, first_v, last_hs, popped, pat;
    bit         got_done, prev_stall;
    for (int k = 0; k < n; k++) exp_q.push_back(mem_a[(int'(b) + k * int'(stride_a)) % DA]);
    @(negedge clk);
    start_a = 1'b1; base_a = b; len_a = 9'(n); ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0; first_v = -1; last_hs = -1; popped = 0; pat = 0;
    got_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (!got_done && cyc < 4000) begin
      start_a = poke && (cyc == 3);
      if (poke && cyc == 3) begin base_a = 8'($urandom); len_a = 9'd5; end
      case (mode)
        0:       ready_a = 1'b1;
        1:       ready_a = 1'($urandom_range(0, 1));
        default: ready_a = (pat % 6 == 0) || (pat % 6 == 3) || (pat % 6 == 5);
      endcase
      pat++;
      if (cyc == 0) begin
        total++; if (busy_a !== 1'b1) $display("FAIL busy_after_start got %b exp 1", busy_a); else passed++;
      end
      if (valid_a && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        total++;
        if (valid_a !== 1'b1 || data_a !== prev_data || last_a !== prev_last)
          $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", valid_a, data_a, last_a, prev_data, prev_last);
        else passed++;
      end
      if (stride_a == 8'd1) begin
        lead = raddr_a - b - 8'(popped);
        total++; if (lead > 8'd2) $display("FAIL read_lead got %0d exp <=2", lead); else passed++;
      end
      if (valid_a && ready_a) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL extra_word got %h exp none", data_a);
        else begin
          if (data_a !== exp_q[0]) $display("FAIL word got %h exp %h", data_a, exp_q[0]); else passed++;
          void'(exp_q.pop_front());
          total++;
          if (last_a !== (exp_q.size() == 0)) $display("FAIL last got %b exp %b", last_a, exp_q.size() == 0);
          else passed++;
        end
        popped++; last_hs = cyc;
      end
      prev_stall = valid_a && !ready_a; prev_data = data_a; prev_last = last_a;
      if (done_a) begin
        got_done = 1'b1;
        total++; if (last_hs != cyc - 1) $display("FAIL done_timing got %0d exp %0d", cyc, last_hs + 1); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL word_count got %0d left exp 0", exp_q.size()); else passed++;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    total++; if (!got_done) $display("FAIL done_timeout got none exp done"); else passed++;
    if (mode == 0 && got_done) begin
      total++; if (first_v != 2) $display("FAIL first_valid got %0d exp 2", first_v); else passed++;
      total++; if (cyc != n + 2) $display("FAIL burst_cycles got %0d exp %0d", cyc, n + 2); else passed++;
    end
    @(negedge clk);
    start_a = 1'b0;
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL idle_after got busy=%b done=%b exp 0 0", busy_a, done_a);
    else passed++;
  endtask

  task automatic burst_b(input logic [7:0] b, input int n);
    int  got, cyc;
    bit  seen_done;
    logic [7:0] e;
    @(negedge clk);
    start_b = 1'b1; base_b = b; len_b = 9'(n); ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; got = 0; cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 1000) begin
      if (valid_b) begin
        e = 8'((int'(b) + got) % DB);
        total++; if (data_b !== e) $display("FAIL np2_word got %0d exp %0d", data_b, e); else passed++;
        total++; if (last_b !== (got == n - 1)) $display("FAIL np2_last got %b exp %b", last_b, got == n - 1); else passed++;
        got++;
      end
      if (done_b) seen_done = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    total++; if (!seen_done) $display("FAIL np2_done got none exp done"); else passed++;
    total++; if (got != n) $display("FAIL np2_count got %0d exp %0d", got, n); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (busy_a !== 1'b0)    $display("FAIL reset_busy got %b exp 0", busy_a); else passed++;
    total++; if (done_a !== 1'b0)    $display("FAIL reset_done got %b exp 0", done_a); else passed++;
    total++; if (valid_a !== 1'b0)   $display("FAIL reset_valid got %b exp 0", valid_a); else passed++;
    total++; if (last_a !== 1'b0)    $display("FAIL reset_last got %b exp 0", last_a); else passed++;
    total++; if (data_a !== 8'h00)   $display("FAIL reset_data got %h exp 00", data_a); else passed++;
    total++; if (raddr_a !== 8'h00)  $display("FAIL reset_addr got %h exp 00", raddr_a); else passed++;
    total++; if (busy_b !== 1'b0 || valid_b !== 1'b0) $display("FAIL reset_b got busy=%b valid=%b exp 0 0", busy_b, valid_b); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    burst_a(8'h10, 4, 0, 1'b0);
  endtask

  task automatic test_wrap();
    burst_a(8'hFE, 4, 0, 1'b0);
    burst_b(8'd198, 3);
    burst_b(8'($urandom_range(0, DB - 1)), DB);
  endtask

  task automatic test_backpressure();
    burst_a(8'($urandom), 6, 2, 1'b0);
  endtask

  task automatic test_len_zero();
    logic [7:0] prev;
    @(negedge clk);
    prev = raddr_a; start_a = 1'b1; len_a = 9'd0; base_a = 8'($urandom);
    @(negedge clk);
    start_a = 1'b0;
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || valid_a !== 1'b0 || raddr_a !== prev)
      $display("FAIL len0_pulse got d=%b b=%b v=%b a=%h exp 1 1 0 %h", done_a, busy_a, valid_a, raddr_a, prev);
    else passed++;
    @(negedge clk);
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0 || raddr_a !== prev)
      $display("FAIL len0_after got d=%b b=%b v=%b a=%h exp 0 0 0 %h", done_a, busy_a, valid_a, raddr_a, prev);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    burst_a(8'($urandom), 6, 1, 1'b1);
    burst_a(8'($urandom), 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    int hs, cyc;
    @(negedge clk);
    start_a = 1'b1; base_a = 8'($urandom); len_a = 9'd8; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; hs = 0; cyc = 0;
    while (hs < 2 && cyc < 50) begin
      if (valid_a && ready_a) hs++;
      if (hs < 2) begin @(negedge clk); cyc++; end
    end
    total++; if (hs != 2) $display("FAIL rst_reach got %0d exp 2", hs); else passed++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0)
      $display("FAIL async_reset got v=%b b=%b d=%b exp 0 0 0", valid_a, busy_a, done_a);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0)
      $display("FAIL post_reset got v=%b b=%b d=%b exp 0 0 0", valid_a, busy_a, done_a);
    else passed++;
    burst_a(8'($urandom), 3, 0, 1'b0);
  endtask

  task automatic test_full_depth();
    burst_a(8'($urandom), DA, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++)
      burst_a(8'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
  endtask

`ifdef BRAM_STREAM_READER_STRIDE_EN
  task automatic test_stride();
    stride_a = 8'h40;
    burst_a(8'h00, 5, 0, 1'b0);
    stride_a = 8'h00;
    burst_a(8'h37, 3, 1, 1'b0);
    stride_a = 8'h01;
  endtask
`endif

  initial begin
    for (int i = 0; i < DA; i++) mem_a[i] = 8'(i);
    for (int i = 0; i < DB; i++) mem_b[i] = 8'(i);
    start_a = 1'b0; base_a = '0; len_a = '0; stride_a = 8'd1; ready_a = 1'b0;
    start_b = 1'b0; base_b = '0; len_b = '0; stride_b = 8'd1; ready_b = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_burst();
    test_full_depth();
    test_random();
`ifdef BRAM_STREAM_READER_STRIDE_EN
    test_stride();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
